// File: rtl/beep_driver.sv
// Event-to-pulse output driver: each accepted event becomes a fixed-width high
// pulse followed by a mandatory low gap, with a saturating replay queue.
module beep_driver #(
  parameter int unsigned ON_TICKS    = 5000,
  parameter int unsigned GAP_TICKS   = 5000,
  parameter int unsigned MAX_PENDING = 7,
  localparam int unsigned PW         = $clog2(MAX_PENDING + 1)
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_event,
  input  logic          i_cancel,
  output logic          o_drive,
  output logic          o_busy,
  output logic [PW-1:0] o_pending,
  output logic          o_overflow
);

  localparam int unsigned CW = 32;
  localparam logic [CW-1:0] ON_LAST  = CW'(ON_TICKS - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_TICKS - 1);
  localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t        state, next_state;
  logic [CW-1:0] cnt, next_cnt;
  logic [PW-1:0] pending, next_pending;
  logic          next_overflow;
  logic          enqueue;

  // Next-state, tick counter and pending-queue update
  always_comb begin
    next_state    = state;
    next_cnt      = cnt + CW'(1);
    next_pending  = pending;
    next_overflow = 1'b0;
    enqueue       = 1'b0;

    case (state)
      IDLE: begin
        next_cnt = '0;
        if (i_event) next_state = ON;
      end
      ON: begin
        enqueue = i_event;
        if (cnt == ON_LAST) begin
          next_state = GAP;
          next_cnt   = '0;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          next_cnt = '0;
          if ((pending != '0) || i_event) begin
            // A same-cycle event takes the slot of the consumed one
            next_state = ON;
            if (!i_event) next_pending = pending - PW'(1);
          end else begin
            next_state = IDLE;
          end
        end else begin
          enqueue = i_event;
        end
      end
      default: begin
        next_state = IDLE;
        next_cnt   = '0;
      end
    endcase

    if (enqueue) begin
      if (pending == PEND_MAX) next_overflow = 1'b1;
      else                     next_pending  = pending + PW'(1);
    end

    // Cancel wins over everything, including a coincident event
    if (i_cancel) begin
      next_state    = IDLE;
      next_cnt      = '0;
      next_pending  = '0;
      next_overflow = 1'b0;
    end
  end

  // Registered state and outputs; drive/busy derive from next_state so they are glitch-free
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      pending    <= '0;
      o_overflow <= 1'b0;
      o_drive    <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      state      <= next_state;
      cnt        <= next_cnt;
      pending    <= next_pending;
      o_overflow <= next_overflow;
      o_drive    <= (next_state == ON);
      o_busy     <= (next_state != IDLE);
    end
  end

  assign o_pending = pending;

endmodule
